// File: rtl/nios_system_sysid_checker.sv
// nios_system_sysid_checker
// Avalon-MM read master that reads the system-ID slave (word 0 = ID,
// word 1 = build timestamp) after reset or on request, compares both words
// against the expected build values and publishes pass/fail status.
// Optional feature macro: SYSID_RECHECK_EN -- when defined, the block
// re-runs the check automatically every RECHECK_PERIOD cycles spent in DONE.
module nios_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1489637740,
  parameter int          READ_LATENCY       = 0,
  parameter int          RECHECK_PERIOD     = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        match,
  output logic        fail_sticky,
  output logic [31:0] captured_id,
  output logic [31:0] captured_ts
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ID_PH = 2'd1,
    TS_PH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Phase counter value on which readdata is sampled.
  localparam logic [3:0] LAT = 4'(READ_LATENCY);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        auto_start_reg, auto_start_next;
  logic [31:0] captured_id_reg, captured_id_next;
  logic [31:0] captured_ts_reg, captured_ts_next;
  logic        id_ok_reg, id_ok_next;
  logic        ts_ok_reg, ts_ok_next;
  logic        match_reg, match_next;
  logic        fail_sticky_reg, fail_sticky_next;
  logic        rerun;
  logic        id_cmp, ts_cmp;

`ifdef SYSID_RECHECK_EN
  // Counter holds cycles left in DONE; loading PERIOD-1 and firing at zero
  // keeps the block in DONE for exactly RECHECK_PERIOD cycles.
  localparam int RC_W = $clog2(RECHECK_PERIOD + 1);
  logic [RC_W-1:0] rc_reg, rc_next;
`else
  // Period only matters when automatic rechecks are built in.
  localparam int unused_recheck_period = RECHECK_PERIOD;
`endif

  // Compare results for the words being latched on the DONE-entry edge.
  assign id_cmp = (captured_id_reg == EXPECTED_ID);
  assign ts_cmp = (readdata == EXPECTED_TIMESTAMP);

  // Next-state and datapath decode; everything holds unless a phase says otherwise.
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    auto_start_next  = auto_start_reg;
    captured_id_next = captured_id_reg;
    captured_ts_next = captured_ts_reg;
    id_ok_next       = id_ok_reg;
    ts_ok_next       = ts_ok_reg;
    match_next       = match_reg;
    fail_sticky_next = fail_sticky_reg;
    rerun            = start;
`ifdef SYSID_RECHECK_EN
    rc_next          = rc_reg;
    rerun            = start | (rc_reg == '0);
`endif
    case (state_reg)
      IDLE: begin
        if (auto_start_reg || start) begin
          state_next      = ID_PH;
          auto_start_next = 1'b0;
          cnt_next        = 4'd0;
        end
      end
      ID_PH: begin
        if (cnt_reg == LAT) begin
          captured_id_next = readdata;
          state_next       = TS_PH;
          cnt_next         = 4'd0;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      TS_PH: begin
        if (cnt_reg == LAT) begin
          captured_ts_next = readdata;
          state_next       = DONE;
          id_ok_next       = id_cmp;
          ts_ok_next       = ts_cmp;
          match_next       = id_cmp & ts_cmp;
          if (!(id_cmp & ts_cmp)) begin
            fail_sticky_next = 1'b1;
          end
`ifdef SYSID_RECHECK_EN
          rc_next = RC_W'(RECHECK_PERIOD - 1);
`endif
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      DONE: begin
        if (rerun) begin
          state_next = ID_PH;
          cnt_next   = 4'd0;
          id_ok_next = 1'b0;
          ts_ok_next = 1'b0;
          match_next = 1'b0;
        end
`ifdef SYSID_RECHECK_EN
        else begin
          rc_next = rc_reg - RC_W'(1);
        end
`endif
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and result registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      cnt_reg         <= 4'd0;
      auto_start_reg  <= 1'b1;
      captured_id_reg <= 32'd0;
      captured_ts_reg <= 32'd0;
      id_ok_reg       <= 1'b0;
      ts_ok_reg       <= 1'b0;
      match_reg       <= 1'b0;
      fail_sticky_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      auto_start_reg  <= auto_start_next;
      captured_id_reg <= captured_id_next;
      captured_ts_reg <= captured_ts_next;
      id_ok_reg       <= id_ok_next;
      ts_ok_reg       <= ts_ok_next;
      match_reg       <= match_next;
      fail_sticky_reg <= fail_sticky_next;
    end
  end

`ifdef SYSID_RECHECK_EN
  // Recheck down-counter, loaded on DONE entry and decremented while in DONE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rc_reg <= '0;
    end else begin
      rc_reg <= rc_next;
    end
  end
`endif

  // Bus and status outputs decoded from registers only.
  always_comb begin
    address     = (state_reg == TS_PH);
    read        = (state_reg == ID_PH) || (state_reg == TS_PH);
    busy        = (state_reg == ID_PH) || (state_reg == TS_PH);
    done        = (state_reg == DONE);
    id_ok       = id_ok_reg;
    ts_ok       = ts_ok_reg;
    match       = match_reg;
    fail_sticky = fail_sticky_reg;
    captured_id = captured_id_reg;
    captured_ts = captured_ts_reg;
  end

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// tb_nios_system_sysid_checker
// Directed test of the system-ID checker: a default-latency instance with a
// combinational slave model, and a READ_LATENCY=2 instance whose slave
// model delays readdata by two cycles.
module tb_nios_system_sysid_checker;

  localparam logic [31:0] TS_GOOD = 32'h58CA116C;
  localparam logic [31:0] ID1_EXP = 32'h12345678;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  // Instance 0: default parameters.
  logic        start0 = 1'b0;
  logic        address0, read0, busy0, done0, id_ok0, ts_ok0, match0, fail0;
  logic [31:0] readdata0, cap_id0, cap_ts0;
  logic [31:0] slave_id = 32'd0;
  logic [31:0] slave_ts = TS_GOOD;

  // Instance 1: READ_LATENCY = 2, non-zero expected ID.
  logic        start1 = 1'b0;
  logic        address1, read1, busy1, done1, id_ok1, ts_ok1, match1, fail1;
  logic [31:0] readdata1, cap_id1, cap_ts1;
  logic [31:0] pipe0, pipe1;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clock = ~clock;

  assign readdata0 = address0 ? slave_ts : slave_id;

  // Two-cycle slave: returns data only while read is high, otherwise 0.
  always @(posedge clock) begin
    pipe0 <= read1 ? (address1 ? TS_GOOD : ID1_EXP) : 32'd0;
    pipe1 <= pipe0;
  end
  assign readdata1 = pipe1;

  nios_system_sysid_checker dut0 (
    .clock(clock), .reset_n(reset_n), .start(start0),
    .address(address0), .read(read0), .readdata(readdata0),
    .busy(busy0), .done(done0), .id_ok(id_ok0), .ts_ok(ts_ok0),
    .match(match0), .fail_sticky(fail0),
    .captured_id(cap_id0), .captured_ts(cap_ts0)
  );

  nios_system_sysid_checker #(
    .EXPECTED_ID(ID1_EXP),
    .READ_LATENCY(2)
  ) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start1),
    .address(address1), .read(read1), .readdata(readdata1),
    .busy(busy1), .done(done1), .id_ok(id_ok1), .ts_ok(ts_ok1),
    .match(match1), .fail_sticky(fail1),
    .captured_id(cap_id1), .captured_ts(cap_ts1)
  );

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end else begin
      $display("ok   %s = %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  task automatic check_all_zero0(input string tag);
    check_vec({tag, ".address"}, {31'd0, address0}, 32'd0);
    check_vec({tag, ".read"}, {31'd0, read0}, 32'd0);
    check_vec({tag, ".busy"}, {31'd0, busy0}, 32'd0);
    check_vec({tag, ".done"}, {31'd0, done0}, 32'd0);
    check_vec({tag, ".id_ok"}, {31'd0, id_ok0}, 32'd0);
    check_vec({tag, ".ts_ok"}, {31'd0, ts_ok0}, 32'd0);
    check_vec({tag, ".match"}, {31'd0, match0}, 32'd0);
    check_vec({tag, ".fail_sticky"}, {31'd0, fail0}, 32'd0);
    check_vec({tag, ".captured_id"}, cap_id0, 32'd0);
    check_vec({tag, ".captured_ts"}, cap_ts0, 32'd0);
  endtask

  // {busy, read, address, done} packed for compact phase checks.
  function automatic logic [31:0] bus0();
    return {28'd0, busy0, read0, address0, done0};
  endfunction
  function automatic logic [31:0] bus1();
    return {28'd0, busy1, read1, address1, done1};
  endfunction

  initial begin
    // Reset state.
    repeat (2) @(posedge clock);
    #1;
    check_all_zero0("reset");
    check_vec("reset.dut1_bus", bus1(), 32'h0);

    // Release reset; automatic check on both instances.
    reset_n = 1'b1;
    tick();
    check_vec("auto.e1.bus0", bus0(), 32'b1100);
    check_vec("lat2.e1.bus1", bus1(), 32'b1100);
    tick();
    check_vec("auto.e2.bus0", bus0(), 32'b1110);
    check_vec("lat2.e2.bus1", bus1(), 32'b1100);
    tick();
    check_vec("auto.e3.bus0", bus0(), 32'b0001);
    check_vec("auto.match", {31'd0, match0}, 32'd1);
    check_vec("auto.captured_id", cap_id0, 32'd0);
    check_vec("auto.captured_ts", cap_ts0, TS_GOOD);
    check_vec("auto.fail_sticky", {31'd0, fail0}, 32'd0);
    check_vec("lat2.e3.bus1", bus1(), 32'b1100);
    for (int e = 4; e <= 6; e++) begin
      tick();
      check_vec($sformatf("lat2.e%0d.bus1", e), bus1(), 32'b1110);
    end
    tick();
    check_vec("lat2.e7.bus1", bus1(), 32'b0001);
    check_vec("lat2.captured_id", cap_id1, ID1_EXP);
    check_vec("lat2.captured_ts", cap_ts1, TS_GOOD);
    check_vec("lat2.match", {31'd0, match1}, 32'd1);

    // Timestamp off by one: ts_ok drops, fail_sticky sets.
    slave_ts = 32'h58CA116D;
    pulse_start0();
    check_vec("badts.e1.bus0", bus0(), 32'b1100);
    tick();
    check_vec("badts.e2.bus0", bus0(), 32'b1110);
    tick();
    check_vec("badts.e3.bus0", bus0(), 32'b0001);
    check_vec("badts.id_ok", {31'd0, id_ok0}, 32'd1);
    check_vec("badts.ts_ok", {31'd0, ts_ok0}, 32'd0);
    check_vec("badts.match", {31'd0, match0}, 32'd0);
    check_vec("badts.fail_sticky", {31'd0, fail0}, 32'd1);
    check_vec("badts.captured_ts", cap_ts0, 32'h58CA116D);

    // Wrong ID word, correct timestamp.
    slave_ts = TS_GOOD;
    slave_id = 32'h00000001;
    pulse_start0();
    check_vec("badid.hold_id", cap_id0, 32'd0);
    check_vec("badid.match_clr", {31'd0, match0}, 32'd0);
    repeat (2) tick();
    check_vec("badid.id_ok", {31'd0, id_ok0}, 32'd0);
    check_vec("badid.ts_ok", {31'd0, ts_ok0}, 32'd1);
    check_vec("badid.captured_id", cap_id0, 32'h00000001);

    // Correct model again: match returns, fail_sticky stays.
    slave_id = 32'd0;
    pulse_start0();
    repeat (2) tick();
    check_vec("recover.match", {31'd0, match0}, 32'd1);
    check_vec("recover.fail_sticky", {31'd0, fail0}, 32'd1);

    // Start during TS_PH is ignored.
    pulse_start0();
    tick();
    check_vec("busystart.tsph", bus0(), 32'b1110);
    pulse_start0();
    check_vec("busystart.done", bus0(), 32'b0001);
    tick();
    check_vec("busystart.no_restart", bus0(), 32'b0001);

`ifndef SYSID_RECHECK_EN
    // Without automatic recheck the block parks in DONE.
    repeat (40) tick();
    check_vec("park.done", bus0(), 32'b0001);
`endif

    // Asynchronous reset in the middle of TS_PH.
    pulse_start0();
    tick();
    check_vec("midrst.tsph", bus0(), 32'b1110);
    #2 reset_n = 1'b0;
    #1;
    check_all_zero0("midrst");
    reset_n = 1'b1;
    repeat (3) tick();
    check_vec("midrst.auto_done", bus0(), 32'b0001);
    check_vec("midrst.match", {31'd0, match0}, 32'd1);
    check_vec("midrst.fail_sticky", {31'd0, fail0}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
